// File: rtl/rvc_pkg.sv
// ---------------------------------------------------------------------------
// rvc_pkg
// Shared constants for the RVC instruction alignment buffer.
//   HW_W      : halfword width; the buffer stores and aligns in these units
//   RVC_FULL  : opcode[1:0] value that marks a 32-bit (non-compressed) insn
//   PC_INC_C  : PC step after a compressed instruction
//   PC_INC_F  : PC step after a full 32-bit instruction
//   is_rvc()  : classifies a halfword by its two opcode bits
// ---------------------------------------------------------------------------
package rvc_pkg;

  localparam int unsigned HW_W     = 16;
  localparam logic [1:0]  RVC_FULL = 2'b11;
  localparam int unsigned PC_INC_C = 2;
  localparam int unsigned PC_INC_F = 4;

  // Only the two low opcode bits decide the instruction length.
  function automatic logic is_rvc(input logic [1:0] op);
    return op != RVC_FULL;
  endfunction

endpackage

// File: rtl/halfword_fifo.sv
// ---------------------------------------------------------------------------
// halfword_fifo
// Circular halfword store with variable push and pop widths (0, 1 or 2
// halfwords per cycle each). Owns the storage, read/write pointers and the
// occupancy count. The caller guarantees it never pushes beyond capacity and
// never pops more than is stored.
// Ports:
//   clk, Rst     : clock, synchronous active-high reset (pointers/count only)
//   i_clear      : synchronous clear of pointers and count (redirect)
//   i_push_n     : number of halfwords to write this cycle
//   i_push_data  : [15:0] goes to wp, [31:16] goes to wp+1
//   i_pop_n      : number of halfwords to retire from the head this cycle
//   o_count      : registered occupancy, 0..DEPTH
//   o_h0, o_h1   : halfwords at rp and rp+1
// ---------------------------------------------------------------------------
module halfword_fifo
  import rvc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              i_clear,
  input  logic [1:0]        i_push_n,
  input  logic [2*HW_W-1:0] i_push_data,
  input  logic [1:0]        i_pop_n,
  output logic [CW-1:0]     o_count,
  output logic [HW_W-1:0]   o_h0,
  output logic [HW_W-1:0]   o_h1
);

  logic [HW_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_rp;
  logic [AW-1:0]   r_wp;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   w_wp1;
  logic [AW-1:0]   w_rp1;

  // DEPTH is a power of two, so plain AW-bit addition wraps the ring.
  assign w_wp1 = r_wp + AW'(1);
  assign w_rp1 = r_rp + AW'(1);

  // Storage carries no reset; stale entries are never presented because
  // validity is derived from the count.
  always_ff @(posedge clk) begin
    if (i_push_n != 2'd0) begin
      r_mem[r_wp] <= i_push_data[HW_W-1:0];
    end
    if (i_push_n == 2'd2) begin
      r_mem[w_wp1] <= i_push_data[2*HW_W-1:HW_W];
    end
  end

  always_ff @(posedge clk) begin
    if (Rst || i_clear) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= r_wp + AW'(i_push_n);
      r_rp    <= r_rp + AW'(i_pop_n);
      r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
    end
  end

  assign o_count = r_count;
  assign o_h0    = r_mem[r_rp];
  assign o_h1    = r_mem[w_rp1];

endmodule

// File: rtl/rvc_align_buffer.sv
// ---------------------------------------------------------------------------
// rvc_align_buffer
// Sits between instruction fetch and decode. Accepts 32-bit fetch words,
// splits them into halfwords and presents one aligned instruction at a time:
// a compressed (16-bit) instruction zero-extended, or a full 32-bit one that
// may straddle two fetch words. Tracks the PC of the presented instruction.
// Ports:
//   clk, Rst        : clock, synchronous active-high reset
//   fetch_valid     : fetch_word is offered
//   fetch_word      : fetched word, low halfword first in program order
//   fetch_ready     : a word offered this cycle is accepted
//   flush           : redirect (branch/trap/trap return); discards contents
//   redirect_addr   : new PC on flush, bit 0 ignored
//   hold            : decode-stage stall; blocks consumption only
//   dec_ready       : decode consumes the presented instruction
//   dec_valid       : ins holds a complete instruction
//   ins             : aligned instruction, zero when dec_valid is low
//   comp_sig        : ins is a compressed instruction
//   pres_addr       : PC of ins
// ---------------------------------------------------------------------------
module rvc_align_buffer
  import rvc_pkg::*;
#(
  parameter int                DEPTH      = 8,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_word,
  output logic              fetch_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              hold,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [31:0]       ins,
  output logic              comp_sig,
  output logic [ADDR_W-1:0] pres_addr
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  // A whole fetch word needs two free slots.
  localparam logic [CW-1:0] PUSH_MAXC = CW'(DEPTH - 2);

  logic [ADDR_W-1:0] r_pc;
  // Set when a redirect lands on the upper halfword of a fetch word: the
  // next fetch word's low half precedes the target and must be skipped.
  logic              r_drop_low;

  logic [CW-1:0]     w_count;
  logic [HW_W-1:0]   w_h0;
  logic [HW_W-1:0]   w_h1;
  logic              w_head_rvc;
  logic              w_ins_ready;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_push_n;
  logic [1:0]        w_pop_n;
  logic [31:0]       w_push_data;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [ADDR_W-1:0] w_pc_step;

  halfword_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .Rst         (Rst),
    .i_clear     (flush),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .i_pop_n     (w_pop_n),
    .o_count     (w_count),
    .o_h0        (w_h0),
    .o_h1        (w_h1)
  );

  // Space is judged on the registered count; a pop in the same cycle does
  // not make room early.
  assign fetch_ready = ~Rst & ~flush & (w_count <= PUSH_MAXC);

  assign w_head_rvc  = is_rvc(w_h0[1:0]);
  // A full instruction whose upper half has not arrived stays invalid.
  assign w_ins_ready = w_head_rvc ? (w_count >= CW'(1)) : (w_count >= CW'(2));
  assign dec_valid   = w_ins_ready & ~Rst;

  always_comb begin
    ins      = '0;
    comp_sig = 1'b0;
    if (dec_valid) begin
      if (w_head_rvc) begin
        ins      = {16'h0000, w_h0};
        comp_sig = 1'b1;
      end else begin
        ins      = {w_h1, w_h0};
      end
    end
  end

  assign w_push = fetch_valid & fetch_ready;
  assign w_pop  = dec_valid & dec_ready & ~hold & ~flush;

  // With drop_low set only the upper halfword is stored, moved into the
  // slot that lands at wp.
  assign w_push_data = r_drop_low ? {16'h0000, fetch_word[31:16]} : fetch_word;
  assign w_push_n    = w_push ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign w_pop_n     = w_pop ? (w_head_rvc ? 2'd1 : 2'd2) : 2'd0;

  assign w_redir_pc = redirect_addr & ~ADDR_W'(1);
  assign w_pc_step  = w_head_rvc ? ADDR_W'(PC_INC_C) : ADDR_W'(PC_INC_F);

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_pc       <= RESET_ADDR;
      r_drop_low <= 1'b0;
    end else if (flush) begin
      r_pc       <= w_redir_pc;
      r_drop_low <= redirect_addr[1];
    end else begin
      if (w_pop) begin
        r_pc <= r_pc + w_pc_step;
      end
      if (w_push) begin
        r_drop_low <= 1'b0;
      end
    end
  end

  assign pres_addr = r_pc;

endmodule

// File: tb/tb_rvc_align_buffer.sv
// ---------------------------------------------------------------------------
// tb_rvc_align_buffer
// Directed bench for rvc_align_buffer. Instance A uses DEPTH=8 with a
// non-zero reset PC; instance B uses DEPTH=4 for the capacity and wrap
// scenario, checked cycle by cycle against a halfword queue model.
// ---------------------------------------------------------------------------
module tb_rvc_align_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        a_rst, a_fv, a_fr, a_fl, a_hd, a_dr, a_dv, a_cs;
  logic [31:0] a_fw, a_ins;
  logic [15:0] a_ra, a_pa;

  logic        b_rst, b_fv, b_fr, b_fl, b_hd, b_dr, b_dv, b_cs;
  logic [31:0] b_fw, b_ins;
  logic [15:0] b_ra, b_pa;

  rvc_align_buffer #(
    .DEPTH      (8),
    .ADDR_W     (16),
    .RESET_ADDR (16'h0040)
  ) u_dut_a (
    .clk           (clk),
    .Rst           (a_rst),
    .fetch_valid   (a_fv),
    .fetch_word    (a_fw),
    .fetch_ready   (a_fr),
    .flush         (a_fl),
    .redirect_addr (a_ra),
    .hold          (a_hd),
    .dec_ready     (a_dr),
    .dec_valid     (a_dv),
    .ins           (a_ins),
    .comp_sig      (a_cs),
    .pres_addr     (a_pa)
  );

  rvc_align_buffer #(
    .DEPTH      (4),
    .ADDR_W     (16),
    .RESET_ADDR (16'h0000)
  ) u_dut_b (
    .clk           (clk),
    .Rst           (b_rst),
    .fetch_valid   (b_fv),
    .fetch_word    (b_fw),
    .fetch_ready   (b_fr),
    .flush         (b_fl),
    .redirect_addr (b_ra),
    .hold          (b_hd),
    .dec_ready     (b_dr),
    .dec_valid     (b_dv),
    .ins           (b_ins),
    .comp_sig      (b_cs),
    .pres_addr     (b_pa)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] e_pc;
  logic        e_fr, e_rvc, e_dv, e_cs;
  logic [31:0] e_ins;
  logic [31:0] wl [4] = '{32'h45014581, 32'h00A00513, 32'h05134501, 32'hBEEF00A0};
  logic [19:0] pat_fv = 20'b1101_1011_0110_1101_1011;
  logic [19:0] pat_hd = 20'b0000_1100_0011_0000_1100;
  logic [19:0] pat_dr = 20'b1111_1011_1101_1110_1111;

  initial begin
    a_rst = 1'b1; a_fv = 1'b0; a_fw = '0; a_fl = 1'b0; a_ra = '0; a_hd = 1'b0; a_dr = 1'b0;
    b_rst = 1'b1; b_fv = 1'b0; b_fw = '0; b_fl = 1'b0; b_ra = '0; b_hd = 1'b0; b_dr = 1'b0;
    #2;
    // Outputs forced quiet while reset is asserted
    chk("rst_dv", 32'(a_dv), 32'd0);
    chk("rst_fr", 32'(a_fr), 32'd0);
    chk("rst_ins", a_ins, 32'h0);
    chk("rst_cs", 32'(a_cs), 32'd0);
    tick;
    chk("rst_pa", 32'(a_pa), 32'h0040);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("idle_fr", 32'(a_fr), 32'd1);
    chk("idle_dv", 32'(a_dv), 32'd0);

    // Single full instruction
    a_fv = 1'b1; a_fw = 32'h00A00513; tick; a_fv = 1'b0; #1;
    chk("full_dv", 32'(a_dv), 32'd1);
    chk("full_cs", 32'(a_cs), 32'd0);
    chk("full_ins", a_ins, 32'h00A00513);
    chk("full_pa", 32'(a_pa), 32'h0040);
    a_dr = 1'b1; tick; a_dr = 1'b0; #1;
    chk("full_pa4", 32'(a_pa), 32'h0044);
    chk("full_dv0", 32'(a_dv), 32'd0);

    // Two compressed instructions in one word
    a_fv = 1'b1; a_fw = 32'h45014581; tick; a_fv = 1'b0; #1;
    chk("cli0_ins", a_ins, 32'h00004581);
    chk("cli0_cs", 32'(a_cs), 32'd1);
    chk("cli0_pa", 32'(a_pa), 32'h0044);
    a_dr = 1'b1; tick; #1;
    chk("cli1_ins", a_ins, 32'h00004501);
    chk("cli1_cs", 32'(a_cs), 32'd1);
    chk("cli1_pa", 32'(a_pa), 32'h0046);
    tick; a_dr = 1'b0; #1;
    chk("cli_dv0", 32'(a_dv), 32'd0);
    chk("cli_pa", 32'(a_pa), 32'h0048);

    // Full instruction straddling two fetch words
    a_fv = 1'b1; a_fw = 32'h05134501; tick; a_fv = 1'b0; #1;
    chk("str_c_dv", 32'(a_dv), 32'd1);
    chk("str_c_ins", a_ins, 32'h00004501);
    a_dr = 1'b1; tick; #1;
    chk("str_wait_dv", 32'(a_dv), 32'd0);
    chk("str_wait_ins", a_ins, 32'h0);
    chk("str_wait_cs", 32'(a_cs), 32'd0);
    chk("str_wait_pa", 32'(a_pa), 32'h004A);
    a_fv = 1'b1; a_fw = 32'hBEEF00A0; tick; a_fv = 1'b0; #1;
    chk("str_dv", 32'(a_dv), 32'd1);
    chk("str_ins", a_ins, 32'h00A00513);
    chk("str_cs", 32'(a_cs), 32'd0);
    tick; a_dr = 1'b0; #1;
    chk("str_pa", 32'(a_pa), 32'h004E);
    chk("str_tail_dv", 32'(a_dv), 32'd0);

    // Flush to an odd-halfword target with a word offered in the same cycle
    a_fl = 1'b1; a_ra = 16'h0103; a_fv = 1'b1; a_fw = 32'h11111111; #1;
    chk("fl_fr", 32'(a_fr), 32'd0);
    tick; a_fl = 1'b0; a_fv = 1'b0; #1;
    chk("fl_dv", 32'(a_dv), 32'd0);
    chk("fl_pa", 32'(a_pa), 32'h0102);
    chk("fl_fr1", 32'(a_fr), 32'd1);
    a_fv = 1'b1; a_fw = 32'h4585FFFF; tick; a_fv = 1'b0; #1;
    chk("fl_up_dv", 32'(a_dv), 32'd1);
    chk("fl_up_cs", 32'(a_cs), 32'd1);
    chk("fl_up_ins", a_ins, 32'h00004585);
    chk("fl_up_pa", 32'(a_pa), 32'h0102);
    a_fv = 1'b1; a_fw = 32'h00A00513; tick; a_fv = 1'b0; #1;
    chk("fl_head_ins", a_ins, 32'h00004585);
    a_dr = 1'b1; tick; a_dr = 1'b0; #1;
    chk("fl_nxt_ins", a_ins, 32'h00A00513);
    chk("fl_nxt_cs", 32'(a_cs), 32'd0);
    chk("fl_nxt_pa", 32'(a_pa), 32'h0104);

    // Build count=3, then reset on top of pending push/pop/flush
    a_dr = 1'b1; tick; #1;
    chk("pre_pa", 32'(a_pa), 32'h0108);
    chk("pre_dv", 32'(a_dv), 32'd0);
    a_dr = 1'b0; a_fv = 1'b1; a_fw = 32'h45014581; tick;
    a_dr = 1'b1; tick; a_fv = 1'b0; a_dr = 1'b0; #1;
    chk("c3_dv", 32'(a_dv), 32'd1);
    chk("c3_ins", a_ins, 32'h00004501);
    chk("c3_pa", 32'(a_pa), 32'h010A);
    chk("c3_fr", 32'(a_fr), 32'd1);
    a_rst = 1'b1; a_fv = 1'b1; a_fw = 32'h00A00513; a_dr = 1'b1; a_fl = 1'b1; a_ra = 16'h0200; #1;
    chk("rst2_dv", 32'(a_dv), 32'd0);
    chk("rst2_fr", 32'(a_fr), 32'd0);
    chk("rst2_ins", a_ins, 32'h0);
    chk("rst2_cs", 32'(a_cs), 32'd0);
    tick; a_rst = 1'b0; a_fv = 1'b0; a_dr = 1'b0; a_fl = 1'b0; #1;
    chk("rst2_after_dv", 32'(a_dv), 32'd0);
    chk("rst2_after_pa", 32'(a_pa), 32'h0040);
    chk("rst2_after_fr", 32'(a_fr), 32'd1);
    a_fv = 1'b1; a_fw = 32'h00A00513; tick; a_fv = 1'b0; #1;
    chk("rst2_new_ins", a_ins, 32'h00A00513);
    chk("rst2_new_pa", 32'(a_pa), 32'h0040);

    // DEPTH=4: fill with decode stalled
    b_fv = 1'b1; b_fw = 32'h45014581; tick; #1;
    chk("b_fr_half", 32'(b_fr), 32'd1);
    b_fw = 32'h00A00513; tick; #1;
    chk("b_fr_full", 32'(b_fr), 32'd0);
    chk("b_dv_full", 32'(b_dv), 32'd1);
    chk("b_ins_full", b_ins, 32'h00004581);
    b_fw = 32'h11111111; tick; b_fv = 1'b0; #1;
    chk("b_fr_still", 32'(b_fr), 32'd0);
    chk("b_ins_still", b_ins, 32'h00004581);

    q = '{16'h4581, 16'h4501, 16'h0513, 16'h00A0};
    e_pc = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      b_fv = pat_fv[i]; b_fw = wl[i % 4]; b_hd = pat_hd[i]; b_dr = pat_dr[i];
      #1;
      e_fr  = (q.size() <= 2);
      e_rvc = 1'b0;
      if (q.size() > 0) e_rvc = (q[0][1:0] != 2'b11);
      e_dv  = e_rvc ? (q.size() >= 1) : (q.size() >= 2);
      e_ins = 32'h0;
      e_cs  = 1'b0;
      if (e_dv) begin
        if (e_rvc) begin
          e_ins = {16'h0000, q[0]};
          e_cs  = 1'b1;
        end else begin
          e_ins = {q[1], q[0]};
        end
      end
      chk($sformatf("b_fr[%0d]", i), 32'(b_fr), 32'(e_fr));
      chk($sformatf("b_dv[%0d]", i), 32'(b_dv), 32'(e_dv));
      chk($sformatf("b_ins[%0d]", i), b_ins, e_ins);
      chk($sformatf("b_cs[%0d]", i), 32'(b_cs), 32'(e_cs));
      chk($sformatf("b_pa[%0d]", i), 32'(b_pa), 32'(e_pc));
      if (e_dv && b_dr && !b_hd) begin
        if (e_rvc) begin
          void'(q.pop_front());
          e_pc = e_pc + 16'd2;
        end else begin
          void'(q.pop_front());
          void'(q.pop_front());
          e_pc = e_pc + 16'd4;
        end
      end
      if (b_fv && e_fr) begin
        q.push_back(b_fw[15:0]);
        q.push_back(b_fw[31:16]);
      end
      tick;
    end
    b_fv = 1'b0; b_hd = 1'b0; b_dr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvc_align_buffer.md
RVC_ALIGN_BUFFER -- requirements
Module: rvc_align_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: buffer capacity in 16-bit halfwords; power of two, at least 4.
REQ-002 SHALL have parameter ADDR_W, default 16: program-counter width.
REQ-003 SHALL have parameter RESET_ADDR, default 0: PC value after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port Rst, input, 1: synchronous active-high reset.
REQ-007 Port fetch_valid, input, 1: fetch word present.
REQ-008 Port fetch_word, input, 32: fetched word, low halfword first.
REQ-009 Port fetch_ready, output, 1: buffer accepts a word this cycle.
REQ-010 Port flush, input, 1: branch, trap or trap_ret redirect.
REQ-011 Port redirect_addr, input, ADDR_W: new PC on flush.
REQ-012 Port hold, input, 1: dbg or mem_hold stall from the decode stage.
REQ-013 Port dec_ready, input, 1: decode consumes the instruction (not hazard).
REQ-014 Port dec_valid, output, 1: ins is complete.
REQ-015 Port ins, output, 32: aligned instruction; compressed instructions are zero-extended.
REQ-016 Port comp_sig, output, 1: ins is 16-bit.
REQ-017 Port pres_addr, output, ADDR_W: PC of ins.

Function
REQ-018 SHALL store halfwords in a circular FIFO with read pointer rp, write pointer wp (log2 DEPTH bits, wrapping modulo DEPTH) and a count of 0..DEPTH.
REQ-019 fetch_ready SHALL be 1 when DEPTH-count is at least 2 and flush is 0; it depends on registered count only, so a same-cycle pop is not counted.
REQ-020 A push (fetch_valid and fetch_ready) SHALL write 2 halfwords (wp, then wp+1), or 1 halfword (fetch_word[31:16]) when the drop_low flag is set; drop_low then clears.
REQ-021 The head halfword h0 SHALL be compressed when h0[1:0] is not 2'b11.
REQ-022 Decoded output: compressed head: dec_valid equals count at least 1, comp_sig=1, ins={16'h0,h0}.
REQ-023 Decoded output: otherwise: dec_valid equals count at least 2, comp_sig=0, ins={h1,h0}.
REQ-024 When dec_valid is 0, ins SHALL be 32'h0 and comp_sig 0; an all-zero ins is treated by decode as a bubble.
REQ-025 dec_valid, ins, comp_sig and pres_addr SHALL be combinational from registered state, giving zero latency from buffer to decode.
REQ-026 A pop SHALL occur when dec_valid, dec_ready, no hold and no flush are all true.
REQ-027 A pop SHALL advance rp by 1 (compressed) or 2 (full), reduce count to match, and advance pc by 2 or 4, wrapping at ADDR_W.
REQ-028 A push and a pop in the same cycle SHALL both take effect: count' = count + pushed - popped.
REQ-029 hold SHALL block pops only; pushes continue while space exists.
REQ-030 flush SHALL take priority over push and pop: count=0, rp=wp=0, pc=redirect_addr, drop_low=redirect_addr[1].
REQ-031 On flush, any fetch word offered in the same cycle SHALL be discarded.
REQ-032 A 32-bit instruction whose halves straddle two fetch words SHALL stay invalid until its upper halfword arrives, with no partial output.
REQ-033 redirect_addr[0] SHALL be ignored, since alignment is to halfwords.

Reset
REQ-034 On Rst, the block SHALL set count=0, rp=wp=0, drop_low=0 and pc=RESET_ADDR.
REQ-035 On Rst, dec_valid=0, ins=0, comp_sig=0 and fetch_ready=0 SHALL hold in the reset cycle.
REQ-036 Rst SHALL take priority over flush, push and pop, including mid-instruction.
REQ-037 Storage contents need not be reset.

Structure
REQ-038 Package rvc_pkg SHALL hold HW_W=16, the RVC_FULL opcode constant 2'b11 and the PC increment constants 2 and 4.
REQ-039 Sub-module halfword_fifo SHALL be used, owning the storage, pointers and count, with push width 0/1/2 and pop width 0/1/2.
REQ-040 The top level SHALL hold the alignment logic, pc and drop_low.

Verification
REQ-041 Reset, then push 32'h00A00513 -> dec_valid=1, comp_sig=0, ins=32'h00A00513, pres_addr=RESET_ADDR; after pop, pres_addr=+4.
REQ-042 Push 32'h45014581 (two c.li) -> two pops: ins=32'h00004581 then 32'h00004501, comp_sig=1, pc +2 each time.
REQ-043 Push 32'h05134501, then 32'h????00A0 -> first cycle: c.li valid, then dec_valid=0 (straddle); after the second push, ins=32'h00A00513, comp_sig=0.
REQ-044 flush with redirect_addr=16'h0102 while a push is offered -> count=0, the next push stores only the upper halfword, and pres_addr=16'h0102.
REQ-045 DEPTH=4 with dec_ready=0 -> after 2 pushes fetch_ready=0, and no overflow or pointer wrap error after 20 mixed push/pop cycles with hold toggling.
REQ-046 Rst asserted with count=3 -> next cycle count=0, dec_valid=0, pres_addr=RESET_ADDR.
